imem_cache_responder: RTL and testbench
=======================================

# imem_cache_responder

Instruction-memory responder that sits between the fetch stage and the slower backing instruction memory. It answers fetch addresses combinationally on a hit. On a miss it asserts a stall toward fetch and refills a whole line over a req/ack word handshake. It is a direct-mapped, read-only instruction cache whose fetch-side ports mirror the fetch stage's memory interface.

## Interface
- LINES, 16, number of cache lines; power of two, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Instr_address_fIF  in  32  fetch address; bits [1:0] ignored.
- Instr1_2IF  out  32  instruction at Instr_address_fIF; valid when Stall_2IF=0.
- Stall_2IF  out  1  fetch must freeze; combinational.
- Flush_IN  in  1  invalidate all lines (single-cycle pulse).
- Mem_req_OUT  out  1  backing-memory word request.
- Mem_addr_OUT  out  32  word-aligned backing-memory address.
- Mem_ack_IN  in  1  backing memory returns Mem_data_IN this cycle.
- Mem_data_IN  in  32  returned word.
- Hit_count_OUT, Miss_count_OUT  out  32 each  only with IMEM_STATS_EN.

## Operation
- Address split: offset = addr[2+log2(LINE_WORDS)-1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: data array LINES×LINE_WORDS×32, tag array, one valid bit per line.
- Hit: valid[index] and tag match.
- State machine:
  - IDLE: Instr1_2IF = data[index][offset] on a hit, else 0. Stall_2IF = miss. On a miss at the clock edge, latch tag and index, clear the word counter, and go to FILL.
  - FILL: Stall_2IF=1 and Mem_req_OUT=1 held continuously. Mem_addr_OUT = {latched tag, latched index, counter, 2'b00}; the fill always starts at word 0 and runs sequentially. Each edge with Mem_ack_IN=1 writes Mem_data_IN to the counter's slot and increments the counter. On the ack of word LINE_WORDS-1, write the tag, set valid, and return to IDLE.
- Instr1_2IF is 0 in FILL.
- Fetch address changing during FILL: the fill still completes for the latched line, then IDLE re-looks-up the current address (possibly a new miss).
- Flush_IN:
  - In IDLE: all valid bits clear at the edge. That edge's miss detection uses the pre-flush state; lookups from the next cycle miss.
  - In FILL: sets a pending flag. At fill completion all valids clear, including the just-filled line, and the flag clears.
  - Flush_IN coinciding with the fill-completion edge behaves as pending.
- Mem_ack_IN outside FILL is ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE, all valid=0, counter=0, pending flush=0, Mem_req_OUT=0, Mem_addr_OUT=0, counters=0. Consequently Stall_2IF=1 and Instr1_2IF=0 until the first fill completes.
- Reset mid-FILL aborts the fill: no partial line becomes valid, and Mem_req_OUT drops asynchronously.
- Hit latency: 0 cycles (combinational, same cycle as address).
- Miss at cycle 0:
  - Mem_req_OUT rises in cycle 1.
  - With ack every cycle, words arrive in cycles 1..LINE_WORDS.
  - IDLE plus hit, Stall_2IF=0, in cycle LINE_WORDS+1.
  - Penalty = LINE_WORDS+1+(total ack wait cycles).
- Mem_addr_OUT changes only on acked edges; it is stable while waiting for ack.
- Counter wraps from LINE_WORDS-1 to 0 exactly at fill completion.

## Configuration
- IMEM_STATS_EN defined:
  - Adds Hit_count_OUT and Miss_count_OUT, reset to 0.
  - Hit count +1 on each IDLE edge with a hit. Miss count +1 on each IDLE→FILL transition.
  - Both counters wrap at 2^32.
- IMEM_STATS_EN undefined: both ports and counters are absent; all other behaviour is identical.

## Test plan
- Cold fetch: release reset, address 0xBFC00000, memory acks every cycle with 0x11110000+word → Stall_2IF=1 for 5 cycles; Mem_addr_OUT sequence is BFC00000, BFC00004, BFC00008, BFC0000C; then Instr1_2IF=0x11110000 with stall=0. Addresses 0xBFC00004/8/C then hit with 0x11110001/2/3.
- Ack wait states: miss at 0xBFC00010 with ack every third cycle → Mem_addr_OUT held between acks; stall lasts 4×3+1 cycles; line 1 valid afterwards.
- Conflict: after line 0 is filled, fetch 0xBFC00100 (same index 0, different tag) → miss and refill; then 0xBFC00000 misses again.
- Flush: Flush_IN in IDLE → the next fetch of a previously hit address stalls. Flush_IN during FILL → the filled line is not valid after completion, and the same address misses again.
- Reset mid-FILL: drop RESET after 2 acks → Mem_req_OUT=0 immediately. After release, the address misses and the fill restarts at word 0.
- IMEM_STATS_EN: cold miss plus 3 hits → Miss_count_OUT=1, Hit_count_OUT=3.

Source files
------------

// File: rtl/imem_cache_responder.sv
// imem_cache_responder: direct-mapped, read-only instruction cache that refills whole lines over a req/ack port.
// Optional feature: define IMEM_STATS_EN to add the Hit_count_OUT / Miss_count_OUT counters.
module imem_cache_responder #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_address_fIF,
  output logic [31:0] Instr1_2IF,
  output logic        Stall_2IF,
  input  logic        Flush_IN,
  output logic        Mem_req_OUT,
  output logic [31:0] Mem_addr_OUT,
  input  logic        Mem_ack_IN,
  input  logic [31:0] Mem_data_IN
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0] Hit_count_OUT,
  output logic [31:0] Miss_count_OUT
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  typedef enum logic {S_IDLE, S_FILL} state_e;
  state_e r_state, w_nextState;

  logic [31:0]      r_data [LINES][LINE_WORDS];
  logic [TW-1:0]    r_tags [LINES];
  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_fillTag;
  logic [IW-1:0]    r_fillIdx;
  logic [OW-1:0]    r_count;
  logic             r_flushPend;

  logic [OW-1:0] w_offset;
  logic [IW-1:0] w_index;
  logic [TW-1:0] w_tag;
  logic          w_hit;
  logic          w_ack;
  logic          w_lastWord;
  logic          w_unusedBits;

  assign w_offset     = Instr_address_fIF[2+OW-1:2];
  assign w_index      = Instr_address_fIF[2+OW+IW-1:2+OW];
  assign w_tag        = Instr_address_fIF[31:2+OW+IW];
  assign w_hit        = r_valid[w_index] && (r_tags[w_index] == w_tag);
  assign w_ack        = (r_state == S_FILL) && Mem_ack_IN;
  assign w_lastWord   = (r_count == {OW{1'b1}});
  assign w_unusedBits = ^Instr_address_fIF[1:0];

  always_comb begin
    w_nextState  = r_state;
    Instr1_2IF   = '0;
    Stall_2IF    = 1'b1;
    Mem_req_OUT  = 1'b0;
    Mem_addr_OUT = '0;
    case (r_state)
      S_IDLE: begin
        Stall_2IF = !w_hit;
        if (w_hit) Instr1_2IF = r_data[w_index][w_offset];
        else       w_nextState = S_FILL;
      end
      S_FILL: begin
        Mem_req_OUT  = 1'b1;
        Mem_addr_OUT = {r_fillTag, r_fillIdx, r_count, 2'b00};
        if (Mem_ack_IN && w_lastWord) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Line storage carries no reset; only the valid bits decide what is visible.
  always_ff @(posedge CLK) begin
    if (w_ack) begin
      r_data[r_fillIdx][r_count] <= Mem_data_IN;
      if (w_lastWord) r_tags[r_fillIdx] <= r_fillTag;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_count     <= '0;
      r_flushPend <= 1'b0;
      r_fillTag   <= '0;
      r_fillIdx   <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (Flush_IN) r_valid <= '0;
          if (!w_hit) begin
            r_fillTag <= w_tag;
            r_fillIdx <= w_index;
            r_count   <= '0;
          end
        end
        S_FILL: begin
          if (Flush_IN) r_flushPend <= 1'b1;
          if (Mem_ack_IN) begin
            r_count <= r_count + 1'b1;
            // A flush seen at any point of the fill discards the new line too.
            if (w_lastWord) begin
              if (r_flushPend || Flush_IN) begin
                r_valid     <= '0;
                r_flushPend <= 1'b0;
              end else begin
                r_valid[r_fillIdx] <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_STATS_EN
  logic [31:0] r_hitCount;
  logic [31:0] r_missCount;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hitCount  <= '0;
      r_missCount <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_hit) r_hitCount  <= r_hitCount + 32'd1;
      else       r_missCount <= r_missCount + 32'd1;
    end
  end

  assign Hit_count_OUT  = r_hitCount;
  assign Miss_count_OUT = r_missCount;
`endif

endmodule

// File: tb/tb_imem_cache_responder.sv
// tb_imem_cache_responder: directed and randomized fetch traffic checked every cycle against a line-level cache model.
module tb_imem_cache_responder;
  localparam int LINES      = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = LINE_WORDS * 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Instr_address_fIF = 32'hBFC00000;
  logic [31:0] Instr1_2IF;
  logic        Stall_2IF;
  logic        Flush_IN = 1'b0;
  logic        Mem_req_OUT;
  logic [31:0] Mem_addr_OUT;
  logic        Mem_ack_IN = 1'b0;
  logic [31:0] Mem_data_IN = 32'd0;
`ifdef IMEM_STATS_EN
  logic [31:0] Hit_count_OUT;
  logic [31:0] Miss_count_OUT;
`endif

  int compared   = 0;
  int mismatched = 0;
  int ackMode    = 0;
  int ackWait    = 0;
  logic [31:0] ackAddrs[$];

  imem_cache_responder #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .Instr_address_fIF(Instr_address_fIF),
    .Instr1_2IF(Instr1_2IF),
    .Stall_2IF(Stall_2IF),
    .Flush_IN(Flush_IN),
    .Mem_req_OUT(Mem_req_OUT),
    .Mem_addr_OUT(Mem_addr_OUT),
    .Mem_ack_IN(Mem_ack_IN),
    .Mem_data_IN(Mem_data_IN)
`ifdef IMEM_STATS_EN
    ,
    .Hit_count_OUT(Hit_count_OUT),
    .Miss_count_OUT(Miss_count_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  // Backing memory contents: each word holds its distance from 0xBFC00000 plus 0x11110000.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'h11110000 + ((addr - 32'hBFC00000) >> 2);
  endfunction

  bit          mValid[LINES];
  logic [31:0] mLineAddr[LINES];
  logic [31:0] mLine[LINES][LINE_WORDS];
  logic [31:0] mPending[$];
  logic [31:0] mFillWords[$];
  logic [31:0] mFillLine;
  bit          mFlushPend;
  logic [31:0] mHits;
  logic [31:0] mMisses;

  function automatic int lineIndex(input logic [31:0] addr);
    return int'((addr / LINE_BYTES) % LINES);
  endfunction

  function automatic bit modelHit(input logic [31:0] addr);
    int idx = lineIndex(addr);
    return mValid[idx] && (mLineAddr[idx] == addr / LINE_BYTES);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
    mPending.delete();
    mFillWords.delete();
    mFlushPend = 1'b0;
    mHits      = 32'd0;
    mMisses    = 32'd0;
  endtask

  task automatic modelStep();
    bit hit;
    int idx;
    if (mPending.size() == 0) begin
      hit = modelHit(Instr_address_fIF);
      if (hit) mHits = mHits + 32'd1;
      if (Flush_IN) for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
      if (!hit) begin
        mMisses   = mMisses + 32'd1;
        mFillLine = Instr_address_fIF / LINE_BYTES;
        for (int w = 0; w < LINE_WORDS; w++) mPending.push_back(mFillLine * LINE_BYTES + 32'(w * 4));
        mFillWords.delete();
      end
    end else begin
      if (Flush_IN) mFlushPend = 1'b1;
      if (Mem_ack_IN) begin
        mFillWords.push_back(memWord(mPending.pop_front()));
        if (mPending.size() == 0) begin
          idx = int'(mFillLine % LINES);
          mLineAddr[idx] = mFillLine;
          for (int w = 0; w < LINE_WORDS; w++) mLine[idx][w] = mFillWords[w];
          mValid[idx] = 1'b1;
          if (mFlushPend) for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
          mFlushPend = 1'b0;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h, expected %08h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareCycle();
    bit          filling = (mPending.size() != 0);
    bit          hit     = modelHit(Instr_address_fIF);
    int          idx     = lineIndex(Instr_address_fIF);
    int          word    = int'((Instr_address_fIF / 4) % LINE_WORDS);
    logic [31:0] expInstr;
    expInstr = (!filling && hit) ? mLine[idx][word] : 32'd0;
    checkOutput("stall", 32'(Stall_2IF), 32'(filling || !hit));
    checkOutput("instr", Instr1_2IF, expInstr);
    checkOutput("memReq", 32'(Mem_req_OUT), 32'(filling));
    checkOutput("memAddr", Mem_addr_OUT, filling ? mPending[0] : 32'd0);
`ifdef IMEM_STATS_EN
    checkOutput("hitCount", Hit_count_OUT, mHits);
    checkOutput("missCount", Miss_count_OUT, mMisses);
`endif
  endtask

  initial begin : compareProc
    forever begin
      @(negedge CLK);
      if (!RESET) modelReset();
      compareCycle();
      @(posedge CLK);
      if (!RESET) modelReset();
      else        modelStep();
    end
  end

  // Memory side: mode 0 acks every cycle, mode 1 every third request cycle, mode 2 at random.
  initial begin : memResponder
    forever begin
      @(posedge CLK);
      #2;
      if (Mem_req_OUT) ackWait++;
      else             ackWait = 0;
      case (ackMode)
        0:       Mem_ack_IN = 1'b1;
        1:       Mem_ack_IN = Mem_req_OUT && (ackWait % 3 == 0);
        default: Mem_ack_IN = 1'($urandom_range(0, 1));
      endcase
      Mem_data_IN = Mem_req_OUT ? memWord(Mem_addr_OUT) : $urandom;
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic flush);
    @(posedge CLK);
    #2;
    Instr_address_fIF = addr;
    Flush_IN          = flush;
  endtask

  task automatic measureStall(input string name, input int expected);
    int n = 0;
    ackAddrs.delete();
    while (n <= 100) begin
      @(negedge CLK);
      if (Mem_req_OUT && Mem_ack_IN) ackAddrs.push_back(Mem_addr_OUT);
      if (!Stall_2IF) break;
      n++;
      @(posedge CLK);
    end
    checkOutput(name, 32'(n), 32'(expected));
  endtask

  task automatic checkHit(input string name, input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(addr, 1'b0);
    @(negedge CLK);
    checkOutput({name, "Stall"}, 32'(Stall_2IF), 32'd0);
    checkOutput({name, "Instr"}, Instr1_2IF, expected);
  endtask

  initial begin : mainProc
    logic [31:0] curAddr;
    logic [31:0] bases[3];
    bases[0] = 32'hBFC00000;
    bases[1] = 32'hBFC00100;
    bases[2] = 32'h00400000;

    @(negedge CLK);
    checkOutput("resetStall", 32'(Stall_2IF), 32'd1);
    checkOutput("resetInstr", Instr1_2IF, 32'd0);
    checkOutput("resetReq", 32'(Mem_req_OUT), 32'd0);

    // Cold fetch with an ack every cycle.
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    measureStall("coldStall", 5);
    checkOutput("coldAckCount", 32'(ackAddrs.size()), 32'd4);
    for (int i = 0; i < 4 && i < ackAddrs.size(); i++)
      checkOutput("coldAddr", ackAddrs[i], 32'hBFC00000 + 32'(i * 4));
    checkOutput("coldInstr", Instr1_2IF, 32'h11110000);
    checkHit("hit1", 32'hBFC00004, 32'h11110001);
    checkHit("hit2", 32'hBFC00008, 32'h11110002);
    checkHit("hit3", 32'hBFC0000C, 32'h11110003);
`ifdef IMEM_STATS_EN
    checkOutput("statsHits", Hit_count_OUT, 32'd3);
    checkOutput("statsMisses", Miss_count_OUT, 32'd1);
`endif

    // Ack wait states: one ack every third cycle.
    ackMode = 1;
    applyStimulus(32'hBFC00010, 1'b0);
    measureStall("waitStall", 13);
    checkOutput("waitInstr", Instr1_2IF, 32'h11110004);
    ackMode = 0;

    // Conflict on index 0.
    applyStimulus(32'hBFC00100, 1'b0);
    measureStall("conflictStall", 5);
    checkOutput("conflictInstr", Instr1_2IF, 32'h11110040);
    applyStimulus(32'hBFC00000, 1'b0);
    measureStall("refetchStall", 5);
    checkOutput("refetchInstr", Instr1_2IF, 32'h11110000);
    checkHit("line1Kept", 32'hBFC00014, 32'h11110005);

    // Flush in IDLE: the flush cycle still hits, the next lookup misses.
    applyStimulus(32'hBFC00000, 1'b1);
    @(negedge CLK);
    checkOutput("flushCycleStall", 32'(Stall_2IF), 32'd0);
    applyStimulus(32'hBFC00014, 1'b0);
    measureStall("postFlushStall", 5);
    checkOutput("postFlushInstr", Instr1_2IF, 32'h11110005);

    // Flush during FILL: the line is dropped and refilled.
    applyStimulus(32'hBFC00020, 1'b0);
    applyStimulus(32'hBFC00020, 1'b1);
    applyStimulus(32'hBFC00020, 1'b0);
    measureStall("flushFillStall", 8);
    checkOutput("flushFillInstr", Instr1_2IF, 32'h11110008);

    // Reset after two acks aborts the fill.
    applyStimulus(32'hBFC00030, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("midFillReq", 32'(Mem_req_OUT), 32'd1);
    checkOutput("midFillAddr", Mem_addr_OUT, 32'hBFC00038);
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("abortReq", 32'(Mem_req_OUT), 32'd0);
    checkOutput("abortAddr", Mem_addr_OUT, 32'd0);
    checkOutput("abortStall", 32'(Stall_2IF), 32'd1);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    measureStall("restartStall", 5);
    checkOutput("restartFirstAddr", ackAddrs.size() > 0 ? ackAddrs[0] : 32'hFFFFFFFF, 32'hBFC00030);
    checkOutput("restartInstr", Instr1_2IF, 32'h1111000C);

    // Random traffic: address churn, conflicts, random ack gaps and flushes.
    ackMode = 2;
    curAddr = 32'hBFC00000;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 0)
        curAddr = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 31) * 4);
      applyStimulus(curAddr, 1'($urandom_range(0, 24) == 0));
    end
    applyStimulus(curAddr, 1'b0);
    repeat (20) @(posedge CLK);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
